// File: rtl/coolgirl_mmc3.sv
// coolgirl_mmc3: CoolGirl multicart MMC3-class mapper with $5xxx config window and A12-filtered scanline IRQ
module coolgirl_mmc3 #(
    parameter int PRG_HI = 26,
    parameter int CHR_HI = 17,
    parameter int A12_FILTER = 3,
    parameter int SRAM_PAGE_BITS = 2
) (
    input  logic                  m2,
    input  logic                  rst_n,
    input  logic                  romsel,
    input  logic                  cpu_rw_in,
    input  logic [14:0]           cpu_addr_in,
    input  logic [7:0]            cpu_data_in,
    output logic [PRG_HI-13:0]    cpu_addr_out,
    output logic                  flash_we,
    output logic                  flash_oe,
    output logic                  sram_ce,
    output logic                  sram_we,
    output logic                  sram_oe,
    input  logic                  ppu_rd_in,
    input  logic                  ppu_wr_in,
    input  logic [13:0]           ppu_addr_in,
    output logic [CHR_HI-10:0]    ppu_addr_out,
    output logic                  ppu_rd_out,
    output logic                  ppu_wr_out,
    output logic                  ppu_ciram_a10,
    output logic                  irq
);
    localparam int PW = PRG_HI - 12;
    localparam int CW = CHR_HI - 9;
    localparam int LW = $clog2(A12_FILTER + 1);
    localparam logic [PW-1:0] LAST = '1;
    localparam logic [PW-1:0] LAST_M1 = {{(PW-1){1'b1}}, 1'b0};

    logic [15:0]               cpu_base;
    logic [PW-1:0]             prg_mask;
    logic [CW-1:0]             chr_base, chr_mask;
    logic [SRAM_PAGE_BITS-1:0] sram_page;
    logic                      lockout, mirroring, prg_we, chr_we, sram_en;
    logic [7:0][7:0]           r;
    logic [2:0]                bank_sel;
    logic                      prg_mode, chr_inv, sram_on, sram_wp;
    logic [7:0]                irq_latch, counter, latch_n, cnt_base, cnt_n;
    logic                      reload, irq_en, pending, reload_base, en_n;
    logic [LW-1:0]             low_cnt;
    logic                      cfg_wr, map_wr, w_c000, w_c001, w_e000, w_e001;
    logic                      a12_event, sram_act, chr_a;
    logic [2:0]                wsel;
    logic [PW-1:0]             prg_bank;
    logic [7:0]                chr_bank;
    logic                      unused;

    assign cfg_wr = romsel & ~cpu_rw_in & ~lockout & (cpu_addr_in[14:12] == 3'b101);
    assign map_wr = ~romsel & ~cpu_rw_in;
    assign wsel = {cpu_addr_in[14:13], cpu_addr_in[0]};
    assign w_c000 = map_wr & (wsel == 3'b100);
    assign w_c001 = map_wr & (wsel == 3'b101);
    assign w_e000 = map_wr & (wsel == 3'b110);
    assign w_e001 = map_wr & (wsel == 3'b111);
    assign unused = ^{cpu_addr_in[11:3], ppu_addr_in[9:0], cpu_base};

    // Config window and MMC3 bank/mode registers, captured on M2 fall
    always_ff @(negedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            cpu_base <= '0;
            prg_mask <= '1;
            chr_base <= '0;
            chr_mask <= '1;
            sram_page <= '0;
            {lockout, mirroring, prg_we, chr_we, sram_en} <= '0;
            r <= '0;
            bank_sel <= '0;
            {prg_mode, chr_inv, sram_on, sram_wp} <= '0;
        end else begin
            if (cfg_wr) begin
                case (cpu_addr_in[2:0])
                    3'd0: cpu_base[15:8] <= cpu_data_in;
                    3'd1: cpu_base[7:0] <= cpu_data_in;
                    3'd2: prg_mask <= PW'(cpu_data_in);
                    3'd3: chr_base <= CW'(cpu_data_in);
                    3'd4: chr_mask <= CW'(cpu_data_in);
                    3'd5: sram_page <= cpu_data_in[SRAM_PAGE_BITS-1:0];
                    3'd7: {lockout, mirroring, prg_we, chr_we, sram_en} <= {cpu_data_in[7], cpu_data_in[3:0]};
                    default: ;
                endcase
            end
            if (map_wr && wsel == 3'b000) {chr_inv, prg_mode, bank_sel} <= {cpu_data_in[7:6], cpu_data_in[2:0]};
            if (map_wr && wsel == 3'b001) r[bank_sel] <= cpu_data_in;
            if (map_wr && wsel == 3'b010) mirroring <= cpu_data_in[0];
            if (map_wr && wsel == 3'b011) {sram_on, sram_wp} <= cpu_data_in[7:6];
        end
    end

    // PRG window bank: mode 1 swaps the $8000 and $C000 windows
    always_comb begin
        prg_bank = cpu_addr_in[14:13] == 2'd0 ? (prg_mode ? LAST_M1 : PW'(r[6])) :
                   cpu_addr_in[14:13] == 2'd1 ? PW'(r[7]) :
                   cpu_addr_in[14:13] == 2'd2 ? (prg_mode ? PW'(r[6]) : LAST_M1) : LAST;
    end

    assign sram_act = romsel & sram_en & sram_on & (cpu_addr_in[14:13] == 2'b11);
    assign cpu_addr_out = sram_act ? PW'(sram_page) : PW'(cpu_base) | (prg_bank & prg_mask);
    assign sram_ce = ~(sram_act & m2);
    assign sram_we = cpu_rw_in | sram_wp;
    assign sram_oe = ~cpu_rw_in;
    assign flash_oe = ~cpu_rw_in | romsel;
    assign flash_we = cpu_rw_in | romsel | ~prg_we;

    // CHR 1 KB bank: R0/R1 are 2 KB pairs, R2..R5 single 1 KB banks
    always_comb begin
        chr_bank = chr_a ? r[3'd2 + {1'b0, ppu_addr_in[11:10]}] :
                   {(ppu_addr_in[11] ? r[1][7:1] : r[0][7:1]), ppu_addr_in[10]};
    end

    assign chr_a = ppu_addr_in[12] ^ chr_inv;
    assign ppu_addr_out = chr_base | (CW'(chr_bank) & chr_mask);
    assign ppu_rd_out = ppu_rd_in | ppu_addr_in[13];
    assign ppu_wr_out = ppu_wr_in | ppu_addr_in[13] | ~chr_we;
    assign ppu_ciram_a10 = mirroring ? ppu_addr_in[11] : ppu_addr_in[10];

    assign a12_event = ppu_addr_in[12] & (low_cnt == LW'(A12_FILTER));

    // Same-edge register writes take effect before the A12 event is applied
    always_comb begin
        latch_n = w_c000 ? cpu_data_in : irq_latch;
        cnt_base = w_c001 ? 8'd0 : counter;
        reload_base = w_c001 | reload;
        en_n = w_e000 ? 1'b0 : (w_e001 | irq_en);
        cnt_n = !a12_event ? cnt_base : (cnt_base == 8'd0 || reload_base) ? latch_n : cnt_base - 8'd1;
    end

    // A12 low-run filter and scanline counter state
    always_ff @(negedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            low_cnt <= '0;
            irq_latch <= '0;
            counter <= '0;
            reload <= 1'b0;
            irq_en <= 1'b0;
            pending <= 1'b0;
        end else begin
            low_cnt <= ppu_addr_in[12] ? '0 : (low_cnt == LW'(A12_FILTER) ? low_cnt : low_cnt + 1'b1);
            irq_latch <= latch_n;
            counter <= cnt_n;
            reload <= reload_base & ~a12_event;
            irq_en <= en_n;
            pending <= ~w_e000 & (pending | (a12_event & en_n & (cnt_n == 8'd0)));
        end
    end

    assign irq = pending ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_coolgirl_mmc3.sv
// tb_coolgirl_mmc3: scoreboard bench for the CoolGirl MMC3 mapper against a behavioural model
module tb_coolgirl_mmc3;
    localparam int PW = 14, CW = 8, F = 3, SPB = 2;
    localparam int L = (1 << PW) - 1, CL = (1 << CW) - 1;

    logic m2 = 1'b1, rst_n = 1'b0, romsel = 1'b1, rw = 1'b1, ppu_rd = 1'b1, ppu_wr = 1'b1;
    logic [14:0] ca = '0;
    logic [7:0] cd = '0;
    logic [13:0] pa = '0;
    logic [PW-1:0] cao;
    logic [CW-1:0] pao;
    logic fwe, foe, sce, swe, soe, prd, pwr, cir;
    wire irq;
    pullup (irq);

    coolgirl_mmc3 #(.PRG_HI(26), .CHR_HI(17), .A12_FILTER(F), .SRAM_PAGE_BITS(SPB)) dut (
        .m2(m2), .rst_n(rst_n), .romsel(romsel), .cpu_rw_in(rw), .cpu_addr_in(ca), .cpu_data_in(cd),
        .cpu_addr_out(cao), .flash_we(fwe), .flash_oe(foe), .sram_ce(sce), .sram_we(swe), .sram_oe(soe),
        .ppu_rd_in(ppu_rd), .ppu_wr_in(ppu_wr), .ppu_addr_in(pa), .ppu_addr_out(pao),
        .ppu_rd_out(prd), .ppu_wr_out(pwr), .ppu_ciram_a10(cir), .irq(irq));

    always #5 m2 = ~m2;

    typedef struct { string name; int kind; int exp; } item_t;
    item_t q[$];
    int total = 0, bad = 0;

    // Behavioural model state
    int cb, pm, chb, chm, sp, lock, mir, pwe, cwe, sen;
    int R[8];
    int sel, pmode, cinv, son, swp, latch, cnt, rld, en, pend;
    bit hist[$];

    function automatic void mreset();
        cb = 0; pm = L; chb = 0; chm = CL; sp = 0;
        lock = 0; mir = 0; pwe = 0; cwe = 0; sen = 0;
        for (int i = 0; i < 8; i++) R[i] = 0;
        sel = 0; pmode = 0; cinv = 0; son = 0; swp = 0;
        latch = 0; cnt = 0; rld = 0; en = 0; pend = 0;
        hist.delete();
    endfunction

    function automatic void model_edge();
        int d = int'(cd);
        int a = int'(ca);
        bit ev;
        hist.push_back(pa[12]);
        if (hist.size() > F + 1) void'(hist.pop_front());
        ev = (hist.size() == F + 1) && hist[F];
        for (int i = 0; i < F; i++) if (hist[i]) ev = 0;
        if (!rw && romsel && ((a >> 12) & 7) == 5 && lock == 0) begin
            case (a & 7)
                0: cb = (cb & 'hFF) | (d << 8);
                1: cb = (cb & 'hFF00) | d;
                2: pm = d;
                3: chb = d & CL;
                4: chm = d & CL;
                5: sp = d & ((1 << SPB) - 1);
                7: begin lock = (d >> 7) & 1; mir = (d >> 3) & 1; pwe = (d >> 2) & 1; cwe = (d >> 1) & 1; sen = d & 1; end
                default: ;
            endcase
        end
        if (!rw && !romsel) begin
            case ((((a >> 13) & 3) << 1) | (a & 1))
                0: begin sel = d & 7; pmode = (d >> 6) & 1; cinv = (d >> 7) & 1; end
                1: R[sel] = d;
                2: mir = d & 1;
                3: begin son = (d >> 7) & 1; swp = (d >> 6) & 1; end
                4: latch = d;
                5: begin cnt = 0; rld = 1; end
                6: begin en = 0; pend = 0; end
                7: en = 1;
                default: ;
            endcase
        end
        if (ev) begin
            if (cnt == 0 || rld != 0) begin cnt = latch; rld = 0; end
            else cnt = cnt - 1;
            if (cnt == 0 && en != 0) pend = 1;
        end
    endfunction

    function automatic int mcpu();
        int a = int'(ca);
        int w = (a >> 13) & 3;
        int bank;
        if (romsel && w == 3 && sen != 0 && son != 0) return sp;
        bank = w == 0 ? (pmode != 0 ? L - 1 : R[6]) : w == 1 ? R[7] : w == 2 ? (pmode != 0 ? R[6] : L - 1) : L;
        return ((cb & L) | (bank & pm)) & L;
    endfunction

    function automatic int mppu();
        int p = int'(pa);
        int bank;
        if ((((p >> 12) & 1) ^ cinv) == 0) bank = ((((p >> 11) & 1) != 0 ? R[1] : R[0]) & 'hFE) | ((p >> 10) & 1);
        else bank = R[2 + ((p >> 10) & 3)];
        return (chb | (bank & chm)) & CL;
    endfunction

    function automatic int mstb();
        int a = int'(ca);
        int act = (romsel && ((a >> 13) & 3) == 3 && sen != 0 && son != 0) ? 1 : 0;
        int r1 = rw ? 1 : 0;
        int rs = romsel ? 1 : 0;
        return (((1 - r1) | rs) << 4) | ((r1 | rs | (1 - pwe)) << 3) | ((1 - act) << 2) | ((r1 | swp) << 1) | (1 - r1);
    endfunction

    function automatic int mchr();
        int a13 = pa[13] ? 1 : 0;
        return (((ppu_rd ? 1 : 0) | a13) << 1) | ((ppu_wr ? 1 : 0) | a13 | (1 - cwe));
    endfunction

    function automatic int actual(int k);
        case (k)
            0: return int'(cao);
            1: return int'(pao);
            2: return irq === 1'b0 ? 0 : 1;
            3: return int'(cir);
            4: return int'({foe, fwe, sce, swe, soe});
            default: return int'({prd, pwr});
        endcase
    endfunction

    // Monitor: compares every queued expectation at the M2 rising edge
    initial forever begin
        @(posedge m2);
        while (q.size() > 0) begin
            item_t it;
            int act;
            it = q.pop_front();
            act = actual(it.kind);
            total++;
            if (act != it.exp) begin
                bad++;
                $display("FAIL %s: got %0h want %0h", it.name, act, it.exp);
            end
        end
    end

    task automatic want(input string n, input int k, input int e);
        item_t it;
        it.name = n; it.kind = k; it.exp = e;
        q.push_back(it);
    endtask

    task automatic step();
        @(negedge m2);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        mreset();
    endtask

    task automatic cpu_wr(input int a16, input int d, input bit a12 = 1'b0);
        romsel = ~a16[15]; ca = a16[14:0]; cd = d[7:0]; rw = 1'b0; pa[12] = a12;
        step();
        rw = 1'b1; romsel = 1'b1; ca = '0; pa[12] = 1'b0;
    endtask

    task automatic rd_chk(input string n, input int a16);
        romsel = ~a16[15]; ca = a16[14:0]; rw = 1'b1;
        want(n, 0, mcpu());
        step();
    endtask

    task automatic ppu_chk(input string n, input int p);
        pa = p[13:0];
        want(n, 1, mppu());
        want({n, "_a10"}, 3, mir != 0 ? int'(pa[11]) : int'(pa[10]));
        step();
    endtask

    task automatic irq_chk(input string n);
        want(n, 2, pend != 0 ? 0 : 1);
        step();
    endtask

    task automatic lows(input int n);
        pa[12] = 1'b0;
        repeat (n) step();
    endtask

    task automatic pulse(input int nlow);
        lows(nlow);
        pa[12] = 1'b1;
        step();
        pa[12] = 1'b0;
    endtask

    initial begin
        mreset();
        @(negedge m2);
        #1;
        rst_n = 1'b1;
        rd_chk("reset_fffc", 'hFFFC);
        irq_chk("reset_irq");
        ppu_chk("reset_ppu2400", 'h2400);
        ppu_chk("reset_ppu2800", 'h2800);
        cpu_wr('h8000, 'h06); cpu_wr('h8001, 'h05); cpu_wr('h8000, 'h46);
        rd_chk("prg_mode1_8000", 'h8000);
        rd_chk("prg_mode1_c000", 'hC000);
        rd_chk("prg_mode1_a000", 'hA000);
        cpu_wr('h8000, 'h82); cpu_wr('h8001, 'h09);
        ppu_chk("chr_inv_0000", 'h0000);
        ppu_chk("chr_inv_1000", 'h1000);
        cpu_wr('hA000, 'h01);
        ppu_chk("mir_h_0c00", 'h0C00);
        cpu_wr('hC000, 3); cpu_wr('hC001, 0); cpu_wr('hE001, 0);
        for (int i = 0; i < 4; i++) begin
            pulse(3);
            irq_chk("irq_count");
        end
        cpu_wr('hE000, 0);
        irq_chk("irq_ack");
        cpu_wr('hC000, 1); cpu_wr('hC001, 0); cpu_wr('hE001, 0);
        pulse(3); irq_chk("filt_reload");
        pulse(2); irq_chk("filt_short");
        pulse(3); irq_chk("filt_fire");
        cpu_wr('hE000, 0); cpu_wr('hC000, 0); cpu_wr('hC001, 0); cpu_wr('hE001, 0);
        pulse(3); irq_chk("latch0_a");
        cpu_wr('hE000, 0); cpu_wr('hE001, 0);
        pulse(3); irq_chk("latch0_b");
        cpu_wr('hE000, 0); cpu_wr('hC000, 1); cpu_wr('hC001, 0); cpu_wr('hE001, 0);
        pulse(3); lows(3);
        cpu_wr('hE000, 0, 1'b1); irq_chk("same_e000");
        pulse(3); lows(3);
        cpu_wr('hE001, 0, 1'b1); irq_chk("same_e001");
        cpu_wr('hE000, 0); cpu_wr('hC000, 2); cpu_wr('hE001, 0); lows(3);
        cpu_wr('hC001, 0, 1'b1); irq_chk("same_c001");
        pulse(3); irq_chk("same_c001_b");
        pulse(3); irq_chk("same_c001_c");
        cpu_wr('hE000, 0); cpu_wr('hE001, 0); lows(3);
        cpu_wr('hC000, 0, 1'b1); irq_chk("same_c000");
        do_reset();
        irq_chk("reset_clears_irq");
        cpu_wr('h8000, 7); cpu_wr('h8001, 3);
        cpu_wr('h5007, 'h80); cpu_wr('h5000, 'h1F);
        rd_chk("lockout_base", 'hA000);
        do_reset();
        cpu_wr('h5000, 'h1F);
        rd_chk("base_hi", 'hA000);
        cpu_wr('h5002, 'h0F);
        rd_chk("base_mask", 'hE000);
        cpu_wr('h5007, 'h07); cpu_wr('hA001, 'h80); cpu_wr('h5005, 2);
        rd_chk("sram_page", 'h6000);
        romsel = 1'b1; ca = 15'h6000; rw = 1'b1; want("sram_rd_stb", 4, mstb()); step();
        rw = 1'b0; want("sram_wr_stb", 4, mstb()); step(); rw = 1'b1;
        cpu_wr('hA001, 'hC0);
        romsel = 1'b1; ca = 15'h6000; rw = 1'b0; want("sram_wp_stb", 4, mstb()); step();
        romsel = 1'b0; ca = 15'h0002; cd = 8'h06; want("flash_wr_stb", 4, mstb()); step();
        rw = 1'b1; romsel = 1'b1;
        for (int i = 0; i < 200; i++) begin
            int k = int'($urandom_range(0, 9));
            int d = int'($urandom_range(0, 255));
            if (k <= 3) cpu_wr('h8000 | int'($urandom_range(0, 1)), d);
            else if (k == 4) cpu_wr('hA000 | int'($urandom_range(0, 1)), d);
            else if (k == 5) begin
                int rg = int'($urandom_range(0, 7));
                cpu_wr('h5000 | rg, rg == 7 ? (d & 'h7F) : d);
            end else if (k == 6) cpu_wr('hC000 | (int'($urandom_range(0, 1)) << 13) | int'($urandom_range(0, 1)), d & 7, 1'($urandom_range(0, 1)));
            romsel = 1'($urandom_range(0, 1)); ca = 15'($urandom); rw = 1'b1;
            pa = 14'($urandom); ppu_rd = 1'($urandom_range(0, 1)); ppu_wr = 1'($urandom_range(0, 1));
            want("rnd_cpu", 0, mcpu());
            want("rnd_stb", 4, mstb());
            want("rnd_ppu", 1, mppu());
            want("rnd_a10", 3, mir != 0 ? int'(pa[11]) : int'(pa[10]));
            want("rnd_chr_stb", 5, mchr());
            want("rnd_irq", 2, pend != 0 ? 0 : 1);
            step();
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge m2);
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
